// File: rtl/mips_pipeline_datapath_pkg.sv
// Shared encodings for the five-stage MIPS-subset pipeline.
// Also holds the register-file reset image and the ALU operation.
package mips_pkg;
  localparam logic [31:0] RESET_PC = 32'd100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_XOR = 4'b0011;
  localparam logic [3:0] ALUC_SUB = 4'b0110;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic [3:0] aluc;
    logic [4:0] dest;
  } ctrl_t;

  function automatic logic [31:0] reg_init(input logic [4:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      5'd1:    v = 32'hA00000AA;
      5'd2:    v = 32'h10000011;
      5'd3:    v = 32'h20000022;
      5'd4:    v = 32'h30000033;
      5'd5:    v = 32'h40000044;
      5'd6:    v = 32'h50000055;
      5'd7:    v = 32'h60000066;
      5'd8:    v = 32'h70000077;
      5'd9:    v = 32'h80000088;
      5'd10:   v = 32'h90000099;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] aluc, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] y;
    y = '0;
    case (aluc)
      ALUC_ADD: y = a + b;
      ALUC_SUB: y = a - b;
      ALUC_AND: y = a & b;
      ALUC_OR:  y = a | b;
      ALUC_XOR: y = a ^ b;
      default:  y = '0;
    endcase
    return y;
  endfunction
endpackage

// File: rtl/mips_pipeline_datapath_if.sv
// Observation bundle: stage registers and write-back value of the pipeline.
// The core drives every signal (master); observers only read (slave).
interface mips_pipeline_datapath_if;
  logic [31:0] pc, dinstOut;
  logic        ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [4:0]  edestReg;
  logic [31:0] eqa, eqb, eimm32, r, b;
  logic [31:0] mr, mqb, mdo;
  logic [4:0]  mdestReg;
  logic        wwreg, wm2reg;
  logic [4:0]  wdestReg;
  logic [31:0] wbr, wdo, wbData;
  logic [1:0]  stall;

  modport master (output pc, dinstOut, ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg,
                  eqa, eqb, eimm32, r, b, mr, mqb, mdestReg, mdo, wwreg, wm2reg,
                  wdestReg, wbr, wdo, wbData, stall);
  modport slave  (input  pc, dinstOut, ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg,
                  eqa, eqb, eimm32, r, b, mr, mqb, mdestReg, mdo, wwreg, wm2reg,
                  wdestReg, wbr, wdo, wbData, stall);
endinterface

// File: rtl/mips_pipeline_datapath_regfile.sv
// 32x32 register file, two combinational read ports, one write port.
// Reset reloads the fixed start-up image; $0 reads 0 and is never written.
module mips_regfile (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  import mips_pkg::*;

  logic [31:0] regs [32];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= reg_init(5'(i));
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

// File: rtl/mips_pipeline_datapath.sv
// Five-stage MIPS-subset core: ROM fetch, ID-stage forwarding with a
// one-bubble load-use stall, ALU in EX, data RAM in MEM, write-back in WB.
module mips_pipeline_datapath #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64
) (
  input  logic clock,
  input  logic resetn,
  mips_pipeline_datapath_if.master dbg
);
  import mips_pkg::*;

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, dinst, inst;
  ctrl_t       dctl, ectl;
  logic [31:0] eqa, eqb, eimm, b_op, r_val;
  logic        mwreg, mm2reg, mwmem, wwreg, wm2reg;
  logic [4:0]  mdest, wdest;
  logic [31:0] mr, mqb, mdo, wbr, wdo, wb_data, mval;
  logic [31:0] rf_a, rf_b, qa, qb, imm32;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic        load_use;

  logic [31:0] dmem [DMEM_WORDS] = '{0: 32'hA00000AA, 1: 32'h10000011,
                                     2: 32'h20000022, 3: 32'h30000033, default: '0};

  // The program occupies byte addresses 100..128, i.e. words 25..32.
  always_comb begin
    inst = '0;
    case (pc_q[IA+1:2])
      IA'(25): inst = 32'h00221820;
      IA'(26): inst = 32'h01432022;
      IA'(27): inst = 32'h006A2825;
      IA'(28): inst = 32'h006A3026;
      IA'(29): inst = 32'h006A3824;
      IA'(30): inst = 32'h8C0B0000;
      IA'(31): inst = 32'h01616020;
      IA'(32): inst = 32'hAC0C0004;
      default: inst = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pc_q  <= RESET_PC;
      dinst <= '0;
    end else if (!load_use) begin
      pc_q  <= pc_q + 32'd4;
      dinst <= inst;
    end
  end

  assign op    = dinst[31:26];
  assign rs    = dinst[25:21];
  assign rt    = dinst[20:16];
  assign rd    = dinst[15:11];
  assign fn    = dinst[5:0];
  assign imm32 = {{16{dinst[15]}}, dinst[15:0]};

  always_comb begin
    dctl = '0;
    case (op)
      OP_RTYPE: begin
        dctl.wreg = 1'b1;
        dctl.dest = rd;
        case (fn)
          FN_ADD:  dctl.aluc = ALUC_ADD;
          FN_SUB:  dctl.aluc = ALUC_SUB;
          FN_AND:  dctl.aluc = ALUC_AND;
          FN_OR:   dctl.aluc = ALUC_OR;
          FN_XOR:  dctl.aluc = ALUC_XOR;
          default: dctl = '0;
        endcase
      end
      OP_LW: begin
        dctl.aluc   = ALUC_ADD;
        dctl.aluimm = 1'b1;
        dctl.m2reg  = 1'b1;
        dctl.wreg   = 1'b1;
        dctl.dest   = rt;
      end
      OP_SW: begin
        dctl.aluc   = ALUC_ADD;
        dctl.aluimm = 1'b1;
        dctl.wmem   = 1'b1;
      end
      default: dctl = '0;
    endcase
  end

  mips_regfile u_regfile (
    .clock(clock), .resetn(resetn), .ra1(rs), .ra2(rt),
    .we(wwreg), .wa(wdest), .wd(wb_data), .rd1(rf_a), .rd2(rf_b)
  );

  assign mval = mm2reg ? mdo : mr;

  // A load still in EX has no data yet; the stall covers that case instead.
  always_comb begin
    qa = rf_a;
    if (rs != 5'd0) begin
      if (ectl.wreg && !ectl.m2reg && ectl.dest == rs) qa = r_val;
      else if (mwreg && mdest == rs)                   qa = mval;
      else if (wwreg && wdest == rs)                   qa = wb_data;
    end
  end

  always_comb begin
    qb = rf_b;
    if (rt != 5'd0) begin
      if (ectl.wreg && !ectl.m2reg && ectl.dest == rt) qb = r_val;
      else if (mwreg && mdest == rt)                   qb = mval;
      else if (wwreg && wdest == rt)                   qb = wb_data;
    end
  end

  assign load_use = ectl.wreg && ectl.m2reg && ectl.dest != 5'd0 &&
                    ((ectl.dest == rs) ||
                     ((ectl.dest == rt) && (op == OP_RTYPE || op == OP_SW)));

  always_ff @(posedge clock) begin
    if (!resetn || load_use) begin
      ectl <= '0;
      eqa  <= '0;
      eqb  <= '0;
      eimm <= '0;
    end else begin
      ectl <= dctl;
      eqa  <= qa;
      eqb  <= qb;
      eimm <= imm32;
    end
  end

  assign b_op  = ectl.aluimm ? eimm : eqb;
  assign r_val = alu(ectl.aluc, eqa, b_op);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mwreg <= 1'b0; mm2reg <= 1'b0; mwmem <= 1'b0;
      mdest <= '0;   mr     <= '0;   mqb   <= '0;
    end else begin
      mwreg <= ectl.wreg; mm2reg <= ectl.m2reg; mwmem <= ectl.wmem;
      mdest <= ectl.dest; mr     <= r_val;      mqb   <= eqb;
    end
  end

  assign mdo = dmem[mr[DA+1:2]];

  always_ff @(posedge clock) begin
    if (mwmem) dmem[mr[DA+1:2]] <= mqb;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wwreg <= 1'b0; wm2reg <= 1'b0; wdest <= '0; wbr <= '0; wdo <= '0;
    end else begin
      wwreg <= mwreg; wm2reg <= mm2reg; wdest <= mdest; wbr <= mr; wdo <= mdo;
    end
  end

  assign wb_data = wm2reg ? wdo : wbr;

  assign dbg.pc       = pc_q;
  assign dbg.dinstOut = dinst;
  assign dbg.ewreg    = ectl.wreg;
  assign dbg.em2reg   = ectl.m2reg;
  assign dbg.ewmem    = ectl.wmem;
  assign dbg.ealuimm  = ectl.aluimm;
  assign dbg.ealuc    = ectl.aluc;
  assign dbg.edestReg = ectl.dest;
  assign dbg.eqa      = eqa;
  assign dbg.eqb      = eqb;
  assign dbg.eimm32   = eimm;
  assign dbg.r        = r_val;
  assign dbg.b        = b_op;
  assign dbg.mr       = mr;
  assign dbg.mqb      = mqb;
  assign dbg.mdestReg = mdest;
  assign dbg.mdo      = mdo;
  assign dbg.wwreg    = wwreg;
  assign dbg.wm2reg   = wm2reg;
  assign dbg.wdestReg = wdest;
  assign dbg.wbr      = wbr;
  assign dbg.wdo      = wdo;
  assign dbg.wbData   = wb_data;
  assign dbg.stall    = {1'b0, load_use};
endmodule

// File: tb/tb_mips_pipeline_datapath.sv
// Bench for the MIPS pipeline: an instruction-level model predicts every
// register write and store; a negedge monitor checks them as they retire.
module tb_mips_pipeline_datapath;
  logic clock = 1'b0;
  logic resetn = 1'b0;

  mips_pipeline_datapath_if dbg ();
  mips_pipeline_datapath dut (.clock(clock), .resetn(resetn), .dbg(dbg));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] exp_q [$];   // {dest, value} of each register write
  logic [95:0] st_q  [$];   // {addr, data, word read before the store}
  logic [31:0] prog  [8];
  logic [31:0] m_mem [64];
  logic [31:0] m_res [8];
  int  stall_cnt = 0;
  bit  stall_prev = 1'b0;
  bit  st_pend = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Architectural (one instruction at a time) execution of the ROM program.
  task automatic run_model(input bit commit);
    logic [31:0] rg [32];
    logic [31:0] mem [64];
    logic [31:0] ins, a, bb, res, addr;
    logic [4:0]  rs, rt, rd;
    rg = '{0: 32'h0, 1: 32'hA00000AA, 2: 32'h10000011, 3: 32'h20000022,
           4: 32'h30000033, 5: 32'h40000044, 6: 32'h50000055, 7: 32'h60000066,
           8: 32'h70000077, 9: 32'h80000088, 10: 32'h90000099, default: 32'h0};
    mem = m_mem;
    for (int i = 0; i < 8; i++) begin
      ins = prog[i];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      a = rg[rs]; bb = rg[rt];
      addr = a + {{16{ins[15]}}, ins[15:0]};
      res = '0;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20: res = a + bb;
            6'h22: res = a - bb;
            6'h24: res = a & bb;
            6'h25: res = a | bb;
            6'h26: res = a ^ bb;
            default: res = '0;
          endcase
          if (rd != 0) begin rg[rd] = res; exp_q.push_back({rd, res}); end
        end
        6'h23: begin
          res = mem[addr[7:2]];
          if (rt != 0) begin rg[rt] = res; exp_q.push_back({rt, res}); end
        end
        6'h2B: begin
          res = addr;
          st_q.push_back({addr, bb, mem[addr[7:2]]});
          mem[addr[7:2]] = bb;
        end
        default: res = '0;
      endcase
      m_res[i] = res;
    end
    if (commit) m_mem = mem;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, dbg.pc, 32'd100);
    check({tag, "_dinst"}, dbg.dinstOut, 32'd0);
    check({tag, "_ectl"}, {19'd0, dbg.ewreg, dbg.em2reg, dbg.ewmem, dbg.ealuimm,
                           dbg.ealuc, dbg.edestReg}, 32'd0);
    check({tag, "_eops"}, dbg.eqa | dbg.eqb | dbg.eimm32 | dbg.r | dbg.b, 32'd0);
    check({tag, "_mem"}, dbg.mr | dbg.mqb | {27'd0, dbg.mdestReg}, 32'd0);
    check({tag, "_wb"}, dbg.wbr | dbg.wdo | dbg.wbData |
                        {25'd0, dbg.wwreg, dbg.wm2reg, dbg.wdestReg}, 32'd0);
    check({tag, "_stall"}, {30'd0, dbg.stall}, 32'd0);
  endtask

  task automatic start_run(input bit commit);
    exp_q.delete();
    st_q.delete();
    run_model(commit);
    stall_cnt = 0;
    resetn = 1'b1;
  endtask

  task automatic end_full_run(input string tag);
    check({tag, "_wb_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_st_left"}, 32'(st_q.size()), 32'd0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd1);
  endtask

  always @(negedge clock) begin
    logic [36:0] e;
    logic [95:0] s;
    if (st_pend) begin
      if (st_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL store_unexpected: got addr %h data %h expected no store", dbg.mr, dbg.mqb);
      end else begin
        s = st_q.pop_front();
        check("store_addr", dbg.mr, s[95:64]);
        check("store_data", dbg.mqb, s[63:32]);
        check("store_old_word", dbg.mdo, s[31:0]);
      end
    end
    st_pend = (resetn === 1'b1) && (dbg.ewmem === 1'b1);
    if (dbg.wwreg === 1'b1 && dbg.wdestReg != 5'd0) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wb_unexpected: got dest %0d value %h expected no write",
                 dbg.wdestReg, dbg.wbData);
      end else begin
        e = exp_q.pop_front();
        check("wb_dest", 32'(dbg.wdestReg), 32'(e[36:32]));
        check("wb_data", dbg.wbData, e[31:0]);
      end
    end
    if (dbg.stall[0] === 1'b1) begin
      stall_cnt++;
      check("stall_pc", dbg.pc, 32'd128);
    end
    if (stall_prev) check("stall_pc_hold", dbg.pc, 32'd128);
    stall_prev = (dbg.stall[0] === 1'b1);
  end

  initial begin
    int k;
    int exp_pc;
    prog[0] = enc_r(1, 2, 3, 6'h20);
    prog[1] = enc_r(10, 3, 4, 6'h22);
    prog[2] = enc_r(3, 10, 5, 6'h25);
    prog[3] = enc_r(3, 10, 6, 6'h26);
    prog[4] = enc_r(3, 10, 7, 6'h24);
    prog[5] = enc_i(6'h23, 0, 11, 16'd0);
    prog[6] = enc_r(11, 1, 12, 6'h20);
    prog[7] = enc_i(6'h2B, 0, 12, 16'd4);
    m_mem = '{0: 32'hA00000AA, 1: 32'h10000011, 2: 32'h20000022, 3: 32'h30000033,
              default: 32'h0};

    resetn = 1'b0;
    tick(); tick();
    check_reset_state("por");

    // first full program run with pipeline-timing checks
    start_run(1'b1);
    tick();
    check("edge1_pc", dbg.pc, 32'd104);
    check("edge1_dinst", dbg.dinstOut, prog[0]);
    tick();
    check("edge2_ealuc", {28'd0, dbg.ealuc}, 32'd2);
    check("edge2_edest", {27'd0, dbg.edestReg}, 32'd3);
    check("edge2_r_add", dbg.r, m_res[0]);
    tick();
    check("edge3_eqb_fwd", dbg.eqb, m_res[0]);
    check("edge3_r_sub", dbg.r, m_res[1]);
    repeat (17) tick();
    end_full_run("run1");

    // randomly truncated runs, all ending before the store can commit
    for (int it = 0; it < 4; it++) begin
      resetn = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      check_reset_state("rnd_rst");
      start_run(1'b0);
      k = $urandom_range(1, 10);
      repeat (k) tick();
      exp_pc = (k <= 7) ? 100 + 4 * k : 100 + 4 * (k - 1);
      check("rnd_pc", dbg.pc, 32'(exp_pc));
    end
    resetn = 1'b0;
    tick();
    check_reset_state("post_rnd");

    // reset asserted while the first add is about to write back
    start_run(1'b0);
    for (int c = 0; c < 20 && dbg.pc !== 32'd116; c++) tick();
    check("mid_pc_reached", dbg.pc, 32'd116);
    resetn = 1'b0;
    tick();
    check_reset_state("mid_rst");
    check("mid_rst_reg3", dut.u_regfile.regs[3], 32'h20000022);

    // second full run: the store sees the word written by the first run
    start_run(1'b1);
    repeat (20) tick();
    end_full_run("run2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
